// File: rtl/int_exec_pipe.sv
// Registered integer execute stage: single-cycle ALU ops plus iterative shifts,
// with a valid/ready result slot. Define INT_EXEC_MUL_EN to add the shift-add multiplier.
module int_exec_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int SHIFT_STEP = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  flush_in,
    input  logic                  valid_in,
    input  logic                  enable_in,
    output logic                  ready_out,
    input  logic [3:0]            uop_in,
    input  logic [DATA_WIDTH-1:0] a_data_in,
    input  logic [DATA_WIDTH-1:0] b_data_in,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic [DATA_WIDTH-1:0] res_data_out,
    output logic                  busy_out
);

    localparam int SHAMT_W = $clog2(DATA_WIDTH);
    localparam int CNT_W   = SHAMT_W + 1;
    localparam logic [CNT_W-1:0] STEP_C = CNT_W'(SHIFT_STEP);

    localparam logic [3:0] UOP_ADD  = 4'b0000;
    localparam logic [3:0] UOP_SUB  = 4'b0001;
    localparam logic [3:0] UOP_OR   = 4'b0010;
    localparam logic [3:0] UOP_AND  = 4'b0011;
    localparam logic [3:0] UOP_XOR  = 4'b0100;
    localparam logic [3:0] UOP_MUL  = 4'b0101;
    localparam logic [3:0] UOP_BUFA = 4'b1000;
    localparam logic [3:0] UOP_BUFB = 4'b1001;
    localparam logic [3:0] UOP_SLT  = 4'b1010;
    localparam logic [3:0] UOP_SLTU = 4'b1011;
    localparam logic [3:0] UOP_SRA  = 4'b1101;
    localparam logic [3:0] UOP_SRL  = 4'b1110;
    localparam logic [3:0] UOP_SLL  = 4'b1111;

    typedef enum logic {
        ST_IDLE,
        ST_ITER
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              op_q, op_d;
    logic [DATA_WIDTH-1:0]   work_q, work_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   res_q, res_d;
    logic                    valid_q, valid_d;
`ifdef INT_EXEC_MUL_EN
    logic [DATA_WIDTH-1:0]   mplr_q, mplr_d;
    logic [DATA_WIDTH-1:0]   acc_q, acc_d;
    logic [DATA_WIDTH-1:0]   mul_sum;
`endif

    logic [SHAMT_W-1:0]      shamt;
    logic                    is_shift;
    logic                    start_iter;
    logic                    out_free;
    logic                    accept;
    logic                    last_step;
    logic [CNT_W-1:0]        step_amt;
    logic [DATA_WIDTH-1:0]   shift_res;
    logic [DATA_WIDTH-1:0]   alu_res;

    assign shamt     = b_data_in[SHAMT_W-1:0];
    assign out_free  = !valid_q || ready_in;
    assign ready_out = (state_q == ST_IDLE) && out_free && !flush_in;
    assign accept    = valid_in && enable_in && ready_out;
    assign busy_out  = (state_q != ST_IDLE);
    assign valid_out = valid_q;
    assign res_data_out = res_q;

    always_comb begin
        is_shift = (uop_in == UOP_SRA) || (uop_in == UOP_SRL) || (uop_in == UOP_SLL);
`ifdef INT_EXEC_MUL_EN
        start_iter = (is_shift && (shamt != '0)) || (uop_in == UOP_MUL);
`else
        start_iter = is_shift && (shamt != '0);
`endif
    end

    // Single-cycle results; shifts reach this path only with a zero shift amount.
    always_comb begin
        alu_res = '0;
        case (uop_in)
            UOP_ADD:  alu_res = a_data_in + b_data_in;
            UOP_SUB:  alu_res = a_data_in - b_data_in;
            UOP_OR:   alu_res = a_data_in | b_data_in;
            UOP_AND:  alu_res = a_data_in & b_data_in;
            UOP_XOR:  alu_res = a_data_in ^ b_data_in;
            UOP_BUFA: alu_res = a_data_in;
            UOP_BUFB: alu_res = b_data_in;
            UOP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_data_in) < $signed(b_data_in))};
            UOP_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, (a_data_in < b_data_in)};
            UOP_SRA,
            UOP_SRL,
            UOP_SLL:  alu_res = a_data_in;
            default:  alu_res = '0;
        endcase
    end

    // For shifts cnt_q holds the shift distance still to apply.
    always_comb begin
        step_amt  = (cnt_q > STEP_C) ? STEP_C : cnt_q;
        shift_res = work_q;
        case (op_q)
            UOP_SRA: shift_res = DATA_WIDTH'($signed(work_q) >>> step_amt);
            UOP_SRL: shift_res = work_q >> step_amt;
            UOP_SLL: shift_res = work_q << step_amt;
            default: shift_res = work_q;
        endcase
    end

`ifdef INT_EXEC_MUL_EN
    always_comb begin
        mul_sum   = acc_q + (mplr_q[0] ? work_q : '0);
        last_step = (op_q == UOP_MUL) ? (cnt_q == CNT_W'(1)) : (cnt_q <= STEP_C);
    end
`else
    always_comb begin
        last_step = (cnt_q <= STEP_C);
    end
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        valid_d = valid_q && !ready_in;
`ifdef INT_EXEC_MUL_EN
        mplr_d  = mplr_q;
        acc_d   = acc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d = uop_in;
                    if (start_iter) begin
                        state_d = ST_ITER;
                        work_d  = a_data_in;
                        cnt_d   = {1'b0, shamt};
`ifdef INT_EXEC_MUL_EN
                        if (uop_in == UOP_MUL) begin
                            cnt_d  = CNT_W'(DATA_WIDTH);
                            mplr_d = b_data_in;
                            acc_d  = '0;
                        end
`endif
                    end else begin
                        res_d   = alu_res;
                        valid_d = 1'b1;
                    end
                end
            end
            ST_ITER: begin
`ifdef INT_EXEC_MUL_EN
                if (op_q == UOP_MUL) begin
                    if (!last_step) begin
                        acc_d  = mul_sum;
                        work_d = work_q << 1;
                        mplr_d = mplr_q >> 1;
                        cnt_d  = cnt_q - CNT_W'(1);
                    end else if (out_free) begin
                        res_d   = mul_sum;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end else
`endif
                if (!last_step) begin
                    work_d = shift_res;
                    cnt_d  = cnt_q - step_amt;
                end else if (out_free) begin
                    // Final step stalls here while an older result still occupies the slot.
                    res_d   = shift_res;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush_in) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
`ifdef INT_EXEC_MUL_EN
            mplr_q  <= '0;
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            valid_q <= valid_d;
`ifdef INT_EXEC_MUL_EN
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
`endif
        end
    end

endmodule
